// File: rtl/pipe_sink_rx.sv
// pipe_sink_rx: clocked receiver at the tail of a req/ack micropipeline.
// Synchronizes the last stage's request, captures its data word with a
// 4-phase handshake, and buffers words in a first-word-fall-through FIFO
// that is drained through a valid/ready port.
//
// Handshakes:
//   pipe_req/pipe_ack is 4-phase (return-to-zero). A word is taken when the
//   synchronized request is high in IDLE and the FIFO is not full. pipe_ack
//   then stays high until the synchronized request is seen low.
//   dout/dout_valid/dout_ready follows valid/ready rules. A word transfers on
//   a rising edge where dout_valid and dout_ready are both 1. dout_valid
//   never depends on dout_ready, and dout is stable while dout_valid=1 and
//   dout_ready=0.
module pipe_sink_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pipe_req,
    input  logic [2:0]    pipe_data,
    output logic          pipe_ack,
    output logic [2:0]    dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          state_dbg,
    output logic [AW:0]   count_dbg
);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    logic [2:0]             mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [AW:0]            count;
    logic                   full;
    logic                   wr_en;
    logic                   rd_en;

    assign req_s      = sync_q[SYNC_STAGES-1];
    // Full is taken from the registered count, so a full FIFO never accepts a
    // word even when a read happens on the same edge.
    assign full       = (count == (AW+1)'(DEPTH));
    assign wr_en      = (state == IDLE) && req_s && !full;
    assign dout_valid = (count != '0);
    assign rd_en      = dout_valid && dout_ready;
    assign dout       = mem[rd_ptr];
    assign state_dbg  = state;
    assign count_dbg  = count;

    // Request synchronizer: shift the asynchronous pipe_req through SYNC_STAGES flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pipe_req};
        end
    end

    // Handshake FSM: capture on the request in IDLE, release ack once the request drops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            pipe_ack <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_en) begin
                        pipe_ack <= 1'b1;
                        state    <= ACK;
                    end
                end
                ACK: begin
                    if (!req_s) begin
                        pipe_ack <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    pipe_ack <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // FIFO storage: pipe_data is stable here because the request is up and the ack is not.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            mem[wr_ptr] <= pipe_data;
        end
    end

    // FIFO pointers and occupancy; a simultaneous read and write leaves count unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_en && !rd_en) begin
                count <= count + (AW+1)'(1);
            end else if (rd_en && !wr_en) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: doc/pipe_sink_rx.md
# pipe_sink_rx

Clocked receiver at the output end of the asynchronous req/ack micropipeline. It synchronizes the last stage's request, captures its 3-bit data word, and returns the acknowledge using a 4-phase (return-to-zero) handshake. Captured words are buffered in a small first-word-fall-through FIFO and presented to synchronous logic with a valid/ready interface. It is the counterpart of the pipeline's request source: it turns the self-timed token stream back into a clocked stream.

## Interface

Parameters:
- SYNC_STAGES, 2: flip-flop depth of the `pipe_req` synchronizer; minimum 2.
- DEPTH, 4: FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the `clk` rising edge.
- pipe_req  input  1  request from the last pipeline stage; asynchronous to `clk`.
- pipe_data  input  3  data from the last pipeline stage; stable while `pipe_req`=1 and `pipe_ack`=0.
- pipe_ack  output  1  acknowledge to the last pipeline stage; registered.
- dout  output  3  head-of-FIFO word.
- dout_valid  output  1  FIFO non-empty.
- dout_ready  input  1  consumer accepts `dout` when `dout_valid`=1 and `dout_ready`=1.

## Operation

- Synchronizer: `pipe_req` passes through SYNC_STAGES flops. The last flop's output is `req_s`. `pipe_data` is not synchronized; it is sampled only while the handshake guarantees it is stable.
- Handshake FSM, 2 states:
  - IDLE: `pipe_ack`=0. If `req_s`=1 and count<DEPTH: write `pipe_data` to `mem[wr_ptr]`, set `pipe_ack`←1, go to ACK. If `req_s`=1 and the FIFO is full: stay in IDLE and do not acknowledge (backpressure on the pipeline).
  - ACK: `pipe_ack`=1. If `req_s`=0: set `pipe_ack`←0 and go to IDLE. Otherwise hold.
- Exactly one FIFO write per 4-phase cycle (req↑, ack↑, req↓, ack↓). A new token is not accepted until `req_s` has been seen low.
- FIFO:
  - `wr_ptr` and `rd_ptr` are log2(DEPTH) bits wide and wrap modulo DEPTH.
  - `count` is log2(DEPTH)+1 bits wide and ranges 0..DEPTH.
  - A write occurs on the IDLE capture. A read occurs when `dout_valid` and `dout_ready` are both 1.
  - Simultaneous read and write: `count` is unchanged and both pointers advance. A write is allowed at count==DEPTH only if a read happens in the same cycle. This block does not do that: the full check uses the registered count, so no write occurs when count==DEPTH.
  - `dout`=`mem[rd_ptr]` (fall-through). `dout_valid`=(count!=0). A read when empty is ignored.
- Reset (rst_n=0 at an edge):
  - state←IDLE, `pipe_ack`←0, synchronizer flops←0, pointers and count←0.
  - FIFO contents are discarded; `dout` is don't-care while `dout_valid`=0.
  - Reset mid-handshake drops `pipe_ack` immediately. The pipeline shares `rst_n`, so no token survives reset.

## Timing

- Reset values: `pipe_ack`=0, `dout_valid`=0.
- Request-to-ack latency: `pipe_req` rises before edge E0, so `req_s`=1 after edge E0+(SYNC_STAGES-1). At the next edge, the data is written and `pipe_ack`=1. Latency is SYNC_STAGES+1 edges with an empty FIFO.
- Ack release: `pipe_ack` falls SYNC_STAGES+1 edges after `pipe_req` falls.
- Capture-to-valid: `dout_valid`=1 in the same cycle that `pipe_ack` first reads 1.
- Throughput: at most one word per 2×(SYNC_STAGES+1) clocks plus the pipeline's own delay.
- Backpressure release: with FIFO full and `req_s`=1, a read at edge R makes count<DEPTH. The capture and `pipe_ack`↑ then happen at edge R+1.

## Test plan

- Single token: reset for 2 cycles. Drive `pipe_data`=3'b101 and raise `pipe_req`. Required: `pipe_ack`=1 3 edges later, `dout`=5, `dout_valid`=1. Drop `pipe_req`; required: `pipe_ack`=0 3 edges later.
- Burst with `dout_ready`=1: send tokens 1,2,3,4,5,6,7,0. Required: `dout` sequence is 1..7,0, with no duplicates and no losses.
- Full/backpressure with `dout_ready`=0: send 6 tokens (0..5). Required: `pipe_ack` completes 4 handshakes and stays 0 on the 5th, and count=4. Then pulse `dout_ready` for 1 cycle. Required: `dout` was 0, `pipe_ack` rises the next edge, and the 5th token is accepted.
- Simultaneous read and write: FIFO holds 2 entries with `dout_ready`=1 during a capture edge. Required: count stays 2 and `dout` advances correctly.
- Pointer wrap: push and pop 10 tokens one at a time. Required: values in order, count returns to 0, `dout_valid`=0.
- Reset mid-handshake: assert `rst_n`=0 while in ACK. Required: at the next edge `pipe_ack`=0, `dout_valid`=0, and the state is IDLE.
